bus_sequencer: RTL and testbench

BUS_SEQUENCER -- requirements
Module: bus_sequencer

---
 rtl/bus_sequencer_pkg.sv | 18 +
 rtl/rr_arb2.sv | 31 +++
 rtl/bus_sequencer.sv | 141 ++++++++++++++
 tb/tb_bus_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bus_sequencer_pkg.sv
// Shared types and constants for the register-to-register bus sequencer.
package bus_sequencer_pkg;

  localparam int NREG_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    LATCH  = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Width of a register-select field for n registers (never narrower than 1 bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer only moves when a grant is accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic prio;

  // Grant the favoured requester when both ask, otherwise whichever one is asking.
  always_comb begin
    grant = 2'b00;
    if (req[0] && (!req[1] || !prio)) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end

  // After granting requester 0 the other one is favoured next, and vice versa.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (accept && (grant != 2'b00)) begin
      prio <= grant[0];
    end
  end

endmodule

// File: rtl/bus_sequencer.sv
// Sequences register-to-register transfers over a shared 8-bit data bus for two requesters.
// Every output is a flop; the grant cycle shows ready while the FSM is still in IDLE,
// and the following cycles show DRIVE, LATCH and FINISH in turn.
module bus_sequencer
  import bus_sequencer_pkg::*;
#(
  parameter int NREG = NREG_DEFAULT,
  parameter int IDW  = idx_width(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [IDW-1:0]  req0_src,
  input  logic [IDW-1:0]  req0_dst,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [IDW-1:0]  req1_src,
  input  logic [IDW-1:0]  req1_dst,
  output logic            req1_ready,
  output logic [NREG-1:0] oe,
  output logic [NREG-1:0] ld,
  output logic            busy,
  output logic [1:0]      done,
  output logic [1:0]      err
);

  localparam logic [IDW:0] NREG_LIMIT = (IDW + 1)'(NREG);

  state_t         state, state_next;
  logic [1:0]     ready, ready_next;
  logic [IDW-1:0] src_q, src_next, dst_q, dst_next;
  logic           owner_q, owner_next;
  logic           bad_q, bad_next;
  logic [NREG-1:0] oe_next, ld_next;
  logic           busy_next;
  logic [1:0]     done_next, err_next;
  logic [1:0]     grant;
  logic           accept, can_grant;
  logic [IDW-1:0] sel_src, sel_dst;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({req1_valid, req0_valid}),
    .accept (accept),
    .grant  (grant)
  );

  // Next state and next registered outputs; a new grant may be issued from an idle
  // FSM with no grant pending, or from FINISH so the grant lands on the first idle cycle.
  always_comb begin
    state_next = state;
    ready_next = 2'b00;
    oe_next    = '0;
    ld_next    = '0;
    busy_next  = 1'b0;
    done_next  = 2'b00;
    err_next   = 2'b00;
    src_next   = src_q;
    dst_next   = dst_q;
    owner_next = owner_q;
    bad_next   = bad_q;
    sel_src    = grant[1] ? req1_src : req0_src;
    sel_dst    = grant[1] ? req1_dst : req0_dst;
    can_grant  = ((state == IDLE) && (ready == 2'b00)) || (state == FINISH);
    accept     = can_grant && (grant != 2'b00);

    case (state)
      IDLE: begin
        if (ready != 2'b00) begin
          if (bad_q) begin
            err_next[owner_q] = 1'b1;
          end else begin
            state_next = DRIVE;
            oe_next    = NREG'(1) << src_q;
            busy_next  = 1'b1;
          end
        end
      end
      DRIVE: begin
        state_next = LATCH;
        oe_next    = NREG'(1) << src_q;
        ld_next    = NREG'(1) << dst_q;
        busy_next  = 1'b1;
      end
      LATCH: begin
        state_next          = FINISH;
        busy_next           = 1'b1;
        done_next[owner_q]  = 1'b1;
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (accept) begin
      ready_next = grant;
      owner_next = grant[1];
      src_next   = sel_src;
      dst_next   = sel_dst;
      bad_next   = (sel_src == sel_dst) || ({1'b0, sel_src} >= NREG_LIMIT) ||
                   ({1'b0, sel_dst} >= NREG_LIMIT);
    end
  end

  // State and output registers; reset drops everything, aborting any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready   <= 2'b00;
      oe      <= '0;
      ld      <= '0;
      busy    <= 1'b0;
      done    <= 2'b00;
      err     <= 2'b00;
      src_q   <= '0;
      dst_q   <= '0;
      owner_q <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state   <= state_next;
      ready   <= ready_next;
      oe      <= oe_next;
      ld      <= ld_next;
      busy    <= busy_next;
      done    <= done_next;
      err     <= err_next;
      src_q   <= src_next;
      dst_q   <= dst_next;
      owner_q <= owner_next;
      bad_q   <= bad_next;
    end
  end

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed self-checking bench for bus_sequencer (NREG=4, 3-bit selects so out-of-range indices can be driven).
module tb_bus_sequencer;

  localparam int NREG = 4;
  localparam int IDW  = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            req0_valid = 1'b0;
  logic [IDW-1:0]  req0_src = '0;
  logic [IDW-1:0]  req0_dst = '0;
  logic            req0_ready;
  logic            req1_valid = 1'b0;
  logic [IDW-1:0]  req1_src = '0;
  logic [IDW-1:0]  req1_dst = '0;
  logic            req1_ready;
  logic [NREG-1:0] oe;
  logic [NREG-1:0] ld;
  logic            busy;
  logic [1:0]      done;
  logic [1:0]      err;

  int checks = 0;
  int failures = 0;

  bus_sequencer #(.NREG(NREG), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_src   (req0_src),
    .req0_dst   (req0_dst),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_src   (req1_src),
    .req1_dst   (req1_dst),
    .req1_ready (req1_ready),
    .oe         (oe),
    .ld         (ld),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // 10 time-unit clock.
  always #5 clk = ~clk;

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle 1 time unit past the edge; check bus exclusivity every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    check("oe_onehot", 32'($countones(oe) <= 1), 32'd1);
    check("ld_onehot", 32'($countones(ld) <= 1), 32'd1);
    check("oe_ld_disjoint", 32'(oe & ld), 32'd0);
  endtask

  task automatic check_outputs(input string tag, input logic [1:0] rdy, input logic [3:0] eoe,
                               input logic [3:0] eld, input logic ebusy, input logic [1:0] edone,
                               input logic [1:0] eerr);
    check({tag, "_ready"}, 32'({req1_ready, req0_ready}), 32'(rdy));
    check({tag, "_oe"},    32'(oe),   32'(eoe));
    check({tag, "_ld"},    32'(ld),   32'(eld));
    check({tag, "_busy"},  32'(busy), 32'(ebusy));
    check({tag, "_done"},  32'(done), 32'(edone));
    check({tag, "_err"},   32'(err),  32'(eerr));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int done0_count;
    int done1_count;
    int grant_idx;

    // Reset state.
    do_reset();
    check_outputs("reset", 2'b00, 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b00);

    // Single transfer 0 -> 1 from requester 0.
    req0_valid = 1'b1; req0_src = 3'd0; req0_dst = 3'd1;
    tick(); check_outputs("t1_c0", 2'b01, 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b00);
    req0_valid = 1'b0;
    tick(); check_outputs("t1_c1", 2'b00, 4'b0001, 4'b0000, 1'b1, 2'b00, 2'b00);
    tick(); check_outputs("t1_c2", 2'b00, 4'b0001, 4'b0010, 1'b1, 2'b00, 2'b00);
    tick(); check_outputs("t1_c3", 2'b00, 4'b0000, 4'b0000, 1'b1, 2'b01, 2'b00);
    tick(); check_outputs("t1_c4", 2'b00, 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b00);

    // Both requesters from reset: requester 0 first, requester 1 right after FINISH.
    do_reset();
    req0_valid = 1'b1; req0_src = 3'd0; req0_dst = 3'd2;
    req1_valid = 1'b1; req1_src = 3'd3; req1_dst = 3'd1;
    tick(); check_outputs("t2_c0", 2'b01, 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b00);
    req0_valid = 1'b0;
    tick(); check_outputs("t2_c1", 2'b00, 4'b0001, 4'b0000, 1'b1, 2'b00, 2'b00);
    tick(); check_outputs("t2_c2", 2'b00, 4'b0001, 4'b0100, 1'b1, 2'b00, 2'b00);
    tick(); check_outputs("t2_c3", 2'b00, 4'b0000, 4'b0000, 1'b1, 2'b01, 2'b00);
    tick(); check_outputs("t2_c4", 2'b10, 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b00);
    req1_valid = 1'b0;
    tick(); check_outputs("t2_c5", 2'b00, 4'b1000, 4'b0000, 1'b1, 2'b00, 2'b00);
    tick(); check_outputs("t2_c6", 2'b00, 4'b1000, 4'b0010, 1'b1, 2'b00, 2'b00);
    tick(); check_outputs("t2_c7", 2'b00, 4'b0000, 4'b0000, 1'b1, 2'b10, 2'b00);
    tick(); check_outputs("t2_c8", 2'b00, 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b00);

    // Continuous back-to-back traffic: grants every 4 cycles, alternating 0,1,0,1...
    req0_valid = 1'b1; req0_src = 3'd0; req0_dst = 3'd1;
    req1_valid = 1'b1; req1_src = 3'd2; req1_dst = 3'd3;
    done0_count = 0;
    done1_count = 0;
    grant_idx = 0;
    for (int c = 0; c < 32; c++) begin
      tick();
      if (c % 4 == 0) begin
        check("t3_grant", 32'({req1_ready, req0_ready}), (grant_idx % 2 == 0) ? 32'd1 : 32'd2);
        grant_idx++;
      end else begin
        check("t3_no_grant", 32'({req1_ready, req0_ready}), 32'd0);
      end
      if (done[0]) done0_count++;
      if (done[1]) done1_count++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("t3_done0_count", 32'(done0_count), 32'd4);
    check("t3_done1_count", 32'(done1_count), 32'd4);
    tick(); check_outputs("t3_drain", 2'b00, 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b00);

    // Rejected requests: src==dst, then an out-of-range source.
    req1_valid = 1'b1; req1_src = 3'd2; req1_dst = 3'd2;
    tick(); check_outputs("t4_same_c0", 2'b10, 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b00);
    req1_valid = 1'b0;
    tick(); check_outputs("t4_same_c1", 2'b00, 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b10);
    req1_valid = 1'b1; req1_src = 3'd5; req1_dst = 3'd1;
    tick(); check_outputs("t4_range_c0", 2'b10, 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b00);
    req1_valid = 1'b0;
    tick(); check_outputs("t4_range_c1", 2'b00, 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b10);
    tick(); check_outputs("t4_range_c2", 2'b00, 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b00);

    // Reset during DRIVE aborts the transfer with no latch and no done.
    req0_valid = 1'b1; req0_src = 3'd1; req0_dst = 3'd3;
    tick(); check_outputs("t5_c0", 2'b01, 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b00);
    req0_valid = 1'b0;
    tick(); check_outputs("t5_c1", 2'b00, 4'b0010, 4'b0000, 1'b1, 2'b00, 2'b00);
    rst = 1'b1;
    tick(); check_outputs("t5_rst", 2'b00, 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b00);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick(); check_outputs("t5_quiet", 2'b00, 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b00);
    end
    req1_valid = 1'b1; req1_src = 3'd3; req1_dst = 3'd0;
    tick(); check_outputs("t5_new_c0", 2'b10, 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b00);
    req1_valid = 1'b0;
    tick(); check_outputs("t5_new_c1", 2'b00, 4'b1000, 4'b0000, 1'b1, 2'b00, 2'b00);
    tick(); check_outputs("t5_new_c2", 2'b00, 4'b1000, 4'b0001, 1'b1, 2'b00, 2'b00);
    tick(); check_outputs("t5_new_c3", 2'b00, 4'b0000, 4'b0000, 1'b1, 2'b10, 2'b00);
    tick(); check_outputs("t5_new_c4", 2'b00, 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b00);

    // Requester 0 held off while busy, then served with its held src/dst.
    req1_valid = 1'b1; req1_src = 3'd0; req1_dst = 3'd3;
    tick(); check_outputs("t6_c0", 2'b10, 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b00);
    req1_valid = 1'b0;
    tick(); check_outputs("t6_c1", 2'b00, 4'b0001, 4'b0000, 1'b1, 2'b00, 2'b00);
    req0_valid = 1'b1; req0_src = 3'd2; req0_dst = 3'd1;
    tick(); check_outputs("t6_c2", 2'b00, 4'b0001, 4'b1000, 1'b1, 2'b00, 2'b00);
    tick(); check_outputs("t6_c3", 2'b00, 4'b0000, 4'b0000, 1'b1, 2'b10, 2'b00);
    tick(); check_outputs("t6_c4", 2'b01, 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b00);
    req0_valid = 1'b0;
    tick(); check_outputs("t6_c5", 2'b00, 4'b0100, 4'b0000, 1'b1, 2'b00, 2'b00);
    tick(); check_outputs("t6_c6", 2'b00, 4'b0100, 4'b0010, 1'b1, 2'b00, 2'b00);
    tick(); check_outputs("t6_c7", 2'b00, 4'b0000, 4'b0000, 1'b1, 2'b01, 2'b00);
    tick(); check_outputs("t6_c8", 2'b00, 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
